variance_calc: RTL and testbench
================================

VARIANCE_CALC -- requirements
Module: variance_calc

Interface
REQ-001 Parameter N, default 4: elements per vector; the block SHALL support N as a power of two, N >= 2.
REQ-002 Parameter DW, default 16: element width, signed Q8.8 two's complement.
REQ-003 Parameter FRAC, default 8: fractional bits of x, mean and var_out.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 x  input  DW x N (unpacked array)  signed input vector.
REQ-007 mean  input  DW  signed mean of x, supplied by the mean stage in the same beat as x.
REQ-008 in_valid  input  1  x and mean are valid.
REQ-009 in_ready  output  1  block can accept a vector.
REQ-010 var_out  output  DW  signed Q8.8 population variance; always non-negative.
REQ-011 out_valid  output  1  var_out is valid.
REQ-012 out_ready  input  1  downstream accepts var_out.

Function
REQ-013 The FSM SHALL have the states IDLE, ACCUM and DONE; in_ready SHALL equal 1 exactly when the state is IDLE, and out_valid SHALL equal 1 exactly when the state is DONE.
REQ-014 Input handshake: on an edge with in_valid=1 in IDLE, the block SHALL register all N elements of x and mean, clear the accumulator and element index, and enter ACCUM.
REQ-015 After capture, the block SHALL ignore the x and mean inputs until the next handshake.
REQ-016 In ACCUM, the block SHALL process one element per clock, in index order 0..N-1, with these widths:
- diff = x[i] - mean, sign-extended to DW+1 bits; no overflow is possible.
- sq = diff*diff, a signed 2*(DW+1)-bit product; sq is always non-negative.
- acc = acc + sq; acc SHALL be 2*(DW+1)+log2(N) bits wide, and no overflow is possible.
REQ-017 On the edge that accumulates element N-1, the block SHALL compute the result and register it into var_out, then enter DONE:
- The Q(2*FRAC) sum acc + sq SHALL be shifted right by log2(N)+FRAC, truncating.
- If the shifted value exceeds 2^(DW-1)-1, var_out SHALL be 0x7FFF for DW=16, i.e. the block saturates.
REQ-018 Latency: with the handshake at edge k, out_valid SHALL first be 1 after edge k+N; for N=4 that is 4 cycles.
REQ-019 In DONE, var_out and out_valid SHALL hold stable while out_ready=0, for any number of cycles.
REQ-020 On an edge with out_valid=1 and out_ready=1, the block SHALL return to IDLE; the next vector can be accepted on the following edge at the earliest.
REQ-021 Throughput: at most one vector per N+2 cycles when out_ready is held at 1.
REQ-022 in_valid seen in ACCUM or DONE SHALL have no effect; upstream SHALL hold x, mean and in_valid until in_ready=1.
REQ-023 Since var_out is updated only on entry to DONE, var_out SHALL retain its last result while the block is in IDLE and ACCUM.

Reset
REQ-024 When rst_n=0, the block SHALL, asynchronously and at any point including mid-ACCUM or in DONE:
- enter IDLE;
- clear the accumulator, index and captured registers;
- drive var_out=0 and out_valid=0;
- drive in_ready=1 once rst_n is deasserted.
REQ-025 A vector that is in flight when reset asserts SHALL be discarded, with no output produced for it.

Verification
REQ-026 x={0x0100,0x0200,0x0300,0x0400}, mean=0x0280, out_ready=1 -> var_out=0x0140 (1.25), with out_valid rising 4 edges after the handshake.
REQ-027 x = four copies of 0x0500, mean=0x0500 -> var_out=0x0000.
REQ-028 Saturation cases, both -> var_out=0x7FFF:
- x = four copies of 0x8000, mean=0x7FFF (diff -255.996, the 17-bit extreme);
- x={0x7FFF,0x8000,0x7FFF,0x8000}, mean=0x0000.
REQ-029 Truncation: x={0x0001,0,0,0}, mean=0 -> var_out=0x0000.
REQ-030 Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new data -> var_out and out_valid stay stable and in_ready stays 0; then assert out_ready for one cycle -> IDLE, and the new vector is accepted on the next edge.
REQ-031 Reset mid-operation: assert rst_n=0 two cycles into ACCUM -> out_valid=0, var_out=0 and in_ready=1 after release; a fresh vector then produces a correct result.

Source files
------------

// File: rtl/variance_calc_if.sv
`default_nettype none
// ============================================================================
// Module   : variance_calc_if
// Purpose  : Vector-in / variance-out handshake bundle for variance_calc.
// Revision : 1.0
// ============================================================================
interface variance_calc_if #(
    parameter int N  = 4,
    parameter int DW = 16
);
    logic signed [DW-1:0] x [N];
    logic signed [DW-1:0] mean;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] var_out;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output x, mean, in_valid, out_ready,
        input  in_ready, var_out, out_valid
    );

    modport slave (
        input  x, mean, in_valid, out_ready,
        output in_ready, var_out, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/variance_calc.sv
`default_nettype none
// ============================================================================
// Module   : variance_calc
// Purpose  : Sequential population variance of an N-element Q8.8 vector.
// Revision : 1.0
// ============================================================================
module variance_calc #(
    parameter int N    = 4,
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    variance_calc_if.slave   bus
);
    localparam int c_LOGN  = $clog2(N);
    localparam int c_DW1   = DW + 1;
    localparam int c_SQW   = 2 * c_DW1;
    localparam int c_ACCW  = c_SQW + c_LOGN;
    localparam int c_SHIFT = c_LOGN + FRAC;

    localparam logic [c_LOGN-1:0] c_IDX_ONE  = c_LOGN'(1);
    localparam logic [c_LOGN-1:0] c_IDX_LAST = c_LOGN'(N - 1);
    localparam logic [c_ACCW-1:0] c_VMAX_ACC = {{(c_ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]     c_VMAX_OUT = {1'b0, {(DW-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic signed [DW-1:0]  r_x [N];
    logic signed [DW-1:0]  r_mean;
    logic [c_LOGN-1:0]     r_idx;
    logic [c_ACCW-1:0]     r_acc;
    logic [DW-1:0]         r_var;

    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_last;
    logic signed [DW-1:0]  w_xi;
    logic signed [c_DW1-1:0] w_diff;
    logic signed [c_SQW-1:0] w_sq;
    logic [c_ACCW-1:0]     w_sum;
    logic [c_ACCW-1:0]     w_shift;
    logic [DW-1:0]         w_sat;

    // One element per cycle: sign-extended difference squared into a wide accumulator.
    assign w_xi    = r_x[r_idx];
    assign w_diff  = $signed({w_xi[DW-1], w_xi}) - $signed({r_mean[DW-1], r_mean});
    assign w_sq    = w_diff * w_diff;
    assign w_sum   = r_acc + {{c_LOGN{1'b0}}, w_sq};
    assign w_shift = w_sum >> c_SHIFT;
    assign w_sat   = (w_shift > c_VMAX_ACC) ? c_VMAX_OUT : w_shift[DW-1:0];
    assign w_last  = (r_idx == c_IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_x[i] <= '0;
            end
            r_mean <= '0;
            r_idx  <= '0;
            r_acc  <= '0;
            r_var  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            r_x[i] <= bus.x[i];
                        end
                        r_mean <= bus.mean;
                        r_idx  <= '0;
                        r_acc  <= '0;
                    end
                end
                S_ACCUM: begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + c_IDX_ONE;
                    // The result register only moves on entry to DONE, so it holds otherwise.
                    if (w_last) begin
                        r_var <= w_sat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.var_out   = r_var;
endmodule
`default_nettype wire

// File: tb/tb_variance_calc.sv
`default_nettype none
// ============================================================================
// Module   : tb_variance_calc
// Purpose  : Directed self-checking bench for variance_calc (N=4, Q8.8).
// Revision : 1.0
// ============================================================================
module tb_variance_calc;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [15:0] prev;

    variance_calc_if #(.N(4), .DW(16)) bus ();

    variance_calc #(.N(4), .DW(16), .FRAC(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] a2, input logic [15:0] a3,
                           input logic [15:0] m);
        bus.x[0] = a0;
        bus.x[1] = a1;
        bus.x[2] = a2;
        bus.x[3] = a3;
        bus.mean = m;
    endtask

    // Handshake, then wait for DONE; leaves the bench sampling inside DONE.
    task automatic run_vec(input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] a2, input logic [15:0] a3,
                           input logic [15:0] m, input logic [15:0] exp,
                           input string tag);
        int lat;
        set_vec(a0, a1, a2, a3, m);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, {31'd0, bus.in_ready}, 32'd0);
        chk({tag, "_hold"}, {16'd0, bus.var_out}, {16'd0, prev});
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, 32'd4);
        chk({tag, "_var"}, {16'd0, bus.var_out}, {16'd0, exp});
        prev = exp;
    endtask

    task automatic release_out(input string tag);
        tick();
        chk({tag, "_idle_rdy"}, {31'd0, bus.in_ready}, 32'd1);
        chk({tag, "_idle_ov"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_idle_var"}, {16'd0, bus.var_out}, {16'd0, prev});
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        prev         = 16'h0000;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        set_vec(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tick();
        tick();
        tick();
        chk("rst_var", {16'd0, bus.var_out}, 32'd0);
        chk("rst_ov", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_rdy", {31'd0, bus.in_ready}, 32'd1);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_rdy", {31'd0, bus.in_ready}, 32'd1);

        run_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0280, 16'h0140, "ramp");
        release_out("ramp");
        run_vec(16'h0500, 16'h0500, 16'h0500, 16'h0500, 16'h0500, 16'h0000, "const");
        release_out("const");
        run_vec(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, "sat_ext");
        release_out("sat_ext");
        run_vec(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, "sat_alt");
        release_out("sat_alt");
        run_vec(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, "trunc0");
        release_out("trunc0");
        run_vec(16'h0021, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, "trunc1");
        release_out("trunc1");
        run_vec(16'hFE00, 16'h0200, 16'hFE00, 16'h0200, 16'h0000, 16'h0400, "neg");
        release_out("neg");

        // Backpressure in DONE with a new vector waiting upstream.
        bus.out_ready = 1'b0;
        run_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0280, 16'h0140, "bp");
        set_vec(16'h0000, 16'h0200, 16'h0000, 16'h0200, 16'h0100);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ov", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_var", {16'd0, bus.var_out}, 32'h0000_0140);
            chk("bp_rdy", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_rel_rdy", {31'd0, bus.in_ready}, 32'd1);
        chk("bp_rel_ov", {31'd0, bus.out_valid}, 32'd0);
        run_vec(16'h0000, 16'h0200, 16'h0000, 16'h0200, 16'h0100, 16'h0100, "bp_next");
        release_out("bp_next");

        // Reset two cycles into ACCUM; the in-flight vector must vanish.
        set_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0280);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_var", {16'd0, bus.var_out}, 32'd0);
        chk("mid_rst_rdy", {31'd0, bus.in_ready}, 32'd1);
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("rel_rdy", {31'd0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        chk("discard_ov", {31'd0, bus.out_valid}, 32'd0);
        chk("discard_var", {16'd0, bus.var_out}, 32'd0);
        prev = 16'h0000;
        run_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0280, 16'h0140, "fresh");
        release_out("fresh");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
